// File: rtl/alu_issue_wb.sv
// -----------------------------------------------------------------------------
// alu_issue_wb
//
// Execution controller wrapped around an external 8-bit combinational ALU.
// It accepts one instruction at a time over a valid/ready handshake. The
// instruction is either a load-immediate, written straight into the register
// file, or an ALU operation. An ALU operation reads two operands from the
// register file into registered ALU inputs. One cycle later it writes the
// ALU result back and updates a sticky carry flag.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   in_valid       instruction present (upstream holds it until accepted)
//   in_ready       high only in IDLE; a transfer is in_valid && in_ready
//   in_load        1 = load immediate, 0 = ALU operation
//   in_opcode      ALU opcode, passed through unchanged
//   in_dst         destination register
//   in_srca        operand A register
//   in_srcb        operand B register
//   in_imm         immediate value for loads
//   alu_opcode     registered opcode driven to the ALU
//   alu_a          registered operand A driven to the ALU
//   alu_b          registered operand B driven to the ALU
//   alu_res        result returned by the ALU
//   alu_carry      carry returned by the ALU
//   done           one-cycle pulse after each register-file write
//   carry_flag     carry from the most recent completed ALU operation
//   rd_addr        debug read address
//   rd_data        combinational rf[rd_addr]
// -----------------------------------------------------------------------------
module alu_issue_wb #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [1:0]       in_opcode,
    input  logic [AW-1:0]    in_dst,
    input  logic [AW-1:0]    in_srca,
    input  logic [AW-1:0]    in_srcb,
    input  logic [WIDTH-1:0] in_imm,
    output logic [1:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    output logic             done,
    output logic             carry_flag,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   rf [NREGS];
    logic [AW-1:0]      dst_q;

    logic               accept;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign rd_data  = rf[rd_addr];

    // NOTE: all sequential state is assigned with non-blocking (<=). The
    // operand reads below must see the register file as it stood before this
    // edge. With <= they do, even when a source register is also the
    // destination.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dst_q      <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            done       <= 1'b0;
            carry_flag <= 1'b0;
            // NOTE: the register file must read zero after reset, so it is
            // cleared here explicitly. This is a small flop array, not a RAM
            // macro, so a per-entry reset is legitimate.
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_load) begin
                            // Load bypasses the ALU and leaves carry_flag alone.
                            rf[in_dst] <= in_imm;
                            done       <= 1'b1;
                        end else begin
                            alu_opcode <= in_opcode;
                            alu_a      <= rf[in_srca];
                            alu_b      <= rf[in_srcb];
                            dst_q      <= in_dst;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // The ALU input registers keep their values after
                    // writeback; downstream only samples them during EXEC.
                    rf[dst_q]  <= alu_res;
                    carry_flag <= alu_carry;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_wb
//
// Self-checking bench for alu_issue_wb. An ALU stub computes
// {carry, res} = a + b for every opcode. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_wb;

    localparam int WIDTH = 8;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_load;
    logic [1:0]       in_opcode;
    logic [AW-1:0]    in_dst;
    logic [AW-1:0]    in_srca;
    logic [AW-1:0]    in_srcb;
    logic [WIDTH-1:0] in_imm;
    logic [1:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             done;
    logic             carry_flag;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    alu_issue_wb #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_opcode  (in_opcode),
        .in_dst     (in_dst),
        .in_srca    (in_srca),
        .in_srcb    (in_srcb),
        .in_imm     (in_imm),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .alu_carry  (alu_carry),
        .done       (done),
        .carry_flag (carry_flag),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    // ALU stub: the same addition for every opcode.
    assign {alu_carry, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            load;
        logic [1:0]      opcode;
        logic [AW-1:0]   dst;
        logic [AW-1:0]   srca;
        logic [AW-1:0]   srcb;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] exp_res;
        logic            exp_carry;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [AW-1:0] addr, input logic [WIDTH-1:0] expected, input string name);
        rd_addr = addr;
        #1;
        check(name, rd_data, expected);
    endtask

    // Issue one instruction and wait (bounded) for its done pulse.
    task automatic issue(input vec_t v, input int idx);
        int n;
        n = 0;
        while (!in_ready && n < 4) begin
            step();
            n++;
        end
        check($sformatf("vec%0d_ready", idx), in_ready, 1);
        in_valid  = 1'b1;
        in_load   = v.load;
        in_opcode = v.opcode;
        in_dst    = v.dst;
        in_srca   = v.srca;
        in_srcb   = v.srcb;
        in_imm    = v.imm;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!done && n < 4) begin
            step();
            n++;
        end
        check($sformatf("vec%0d_done", idx), done, 1);
        check($sformatf("vec%0d_latency", idx), n, v.load ? 0 : 1);
        read_reg(v.dst, v.exp_res, $sformatf("vec%0d_res", idx));
        check($sformatf("vec%0d_carry", idx), carry_flag, v.exp_carry);
        step();
    endtask

    initial begin
        // Table of directed vectors. Register contents on entry:
        // r0=200 r1=200 r2=44 r3=144, carry_flag=1.
        vecs[0] = '{load:1, opcode:2'd0, dst:2'd0, srca:2'd0, srcb:2'd0, imm:8'd5,   exp_res:8'd5,   exp_carry:1}; // carry unchanged
        vecs[1] = '{load:0, opcode:2'd0, dst:2'd2, srca:2'd0, srcb:2'd0, imm:8'd0,   exp_res:8'd10,  exp_carry:0}; // 5+5
        vecs[2] = '{load:0, opcode:2'd1, dst:2'd1, srca:2'd1, srcb:2'd1, imm:8'd0,   exp_res:8'd144, exp_carry:1}; // 200+200, src==dst
        vecs[3] = '{load:1, opcode:2'd0, dst:2'd3, srca:2'd0, srcb:2'd0, imm:8'd255, exp_res:8'd255, exp_carry:1};
        vecs[4] = '{load:0, opcode:2'd2, dst:2'd0, srca:2'd3, srcb:2'd2, imm:8'd0,   exp_res:8'd9,   exp_carry:1}; // 255+10
        vecs[5] = '{load:0, opcode:2'd3, dst:2'd2, srca:2'd1, srcb:2'd3, imm:8'd0,   exp_res:8'd143, exp_carry:1}; // 144+255

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_opcode = '0;
        in_dst    = '0;
        in_srca   = '0;
        in_srcb   = '0;
        in_imm    = '0;
        rd_addr   = '0;
        step();
        step();
        reset = 1'b0;
        #1;

        // Reset state.
        for (int i = 0; i < NREGS; i++) begin
            read_reg(AW'(i), 8'd0, $sformatf("reset_r%0d", i));
        end
        check("reset_ready", in_ready, 1);
        check("reset_carry", carry_flag, 0);
        check("reset_done", done, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_opcode", alu_opcode, 0);

        // Back-to-back loads: r0=200, r1=100.
        in_valid = 1'b1;
        in_load  = 1'b1;
        in_dst   = 2'd0;
        in_imm   = 8'd200;
        step();
        check("load0_done", done, 1);
        check("load0_ready", in_ready, 1);
        in_dst = 2'd1;
        in_imm = 8'd100;
        step();
        check("load1_done", done, 1);
        in_valid = 1'b0;
        step();
        check("load_done_low", done, 0);
        read_reg(2'd0, 8'd200, "load_r0");
        read_reg(2'd1, 8'd100, "load_r1");
        check("load_carry", carry_flag, 0);

        // ALU op r2 = r0 + r1, opcode 11.
        in_valid  = 1'b1;
        in_load   = 1'b0;
        in_opcode = 2'b11;
        in_dst    = 2'd2;
        in_srca   = 2'd0;
        in_srcb   = 2'd1;
        step();
        in_valid = 1'b0;
        check("op1_ready_exec", in_ready, 0);
        check("op1_done_exec", done, 0);
        check("op1_alu_opcode", alu_opcode, 2'b11);
        check("op1_alu_a", alu_a, 200);
        check("op1_alu_b", alu_b, 100);
        step();
        check("op1_ready_back", in_ready, 1);
        check("op1_done", done, 1);
        check("op1_carry", carry_flag, 1);
        read_reg(2'd2, 8'd44, "op1_r2");
        step();
        check("op1_done_single", done, 0);

        // r1 = r1 + r1, then r3 = r1 + r0 held on in_valid during EXEC.
        in_valid  = 1'b1;
        in_opcode = 2'b00;
        in_dst    = 2'd1;
        in_srca   = 2'd1;
        in_srcb   = 2'd1;
        step();
        in_dst  = 2'd3;
        in_srca = 2'd1;
        in_srcb = 2'd0;
        check("hold_ready_exec", in_ready, 0);
        check("hold_alu_a", alu_a, 100);
        check("hold_alu_b", alu_b, 100);
        step();
        check("hold_op1_done", done, 1);
        check("hold_op1_carry", carry_flag, 0);
        check("hold_ready_back", in_ready, 1);
        read_reg(2'd1, 8'd200, "hold_r1");
        read_reg(2'd3, 8'd0, "hold_r3_untouched");
        step();
        in_valid = 1'b0;
        check("raw_ready_exec", in_ready, 0);
        check("raw_alu_a", alu_a, 200);
        check("raw_alu_b", alu_b, 200);
        check("raw_done_exec", done, 0);
        step();
        check("raw_done", done, 1);
        check("raw_carry", carry_flag, 1);
        read_reg(2'd3, 8'd144, "raw_r3");
        step();

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i], i);
        end

        // Reset during EXEC of r3 = r0 + r1 (9 + 144) aborts the writeback.
        in_valid  = 1'b1;
        in_load   = 1'b0;
        in_opcode = 2'b01;
        in_dst    = 2'd3;
        in_srca   = 2'd0;
        in_srcb   = 2'd1;
        step();
        in_valid = 1'b0;
        check("abort_in_exec", in_ready, 0);
        check("abort_alu_a", alu_a, 9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_carry", carry_flag, 0);
        check("abort_ready", in_ready, 1);
        check("abort_alu_a_cleared", alu_a, 0);
        read_reg(2'd3, 8'd0, "abort_r3");
        step();
        check("abort_done_after", done, 0);
        check("abort_carry_after", carry_flag, 0);
        read_reg(2'd3, 8'd0, "abort_r3_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
